// File: rtl/lap_stopwatch_pkg.sv
// Shared types and constants for the lap_stopwatch core: BCD digit type,
// control state encoding, digit limits and the packed display width.
package lap_stopwatch_pkg;

  localparam int unsigned BCD_W = 24;

  typedef logic [3:0] bcd_t;

  localparam bcd_t LIM_9 = 4'd9;
  localparam bcd_t LIM_5 = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Wrap limit of digit idx in the chain (0 = cs units ... 5 = min tens).
  function automatic bcd_t digit_limit(input int unsigned idx);
    case (idx)
      32'd3, 32'd5: digit_limit = LIM_5;
      default:      digit_limit = LIM_9;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit of the stopwatch count chain. Steps when en_i is high,
// wraps to 0 after LIMIT and raises carry_o in that same cycle so the next
// digit can step on the same edge.
module bcd_digit
  import lap_stopwatch_pkg::*;
#(
  parameter bcd_t LIMIT   = LIM_9,
  parameter bcd_t RST_VAL = 4'd0
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output bcd_t digit_o,
  output logic carry_o
);

  bcd_t digit_q;
  bcd_t digit_d;
  logic at_lim_s;

  assign at_lim_s = (digit_q == LIMIT);
  assign carry_o  = en_i & at_lim_s;
  assign digit_o  = digit_q;

  // Next digit: clear wins, otherwise step with wrap at LIMIT.
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (en_i) begin
      digit_d = at_lim_s ? 4'd0 : (digit_q + 4'd1);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register, synchronous active-low reset to the preload value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digit_q <= RST_VAL;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: run/pause/clear stopwatch with mm:ss.cc BCD count, split
// freeze and optional lap-capture FIFO.
// Build option: define LAP_STOPWATCH_FIFO_EN to include the lap FIFO;
// without it lap_valid/lap_data/lap_overrun are 0 and lap_read is ignored.
// RESET_VAL is the count loaded by reset (0 in normal use; a nonzero value
// lets a bench start near the 59:59.99 wrap). Clears always go to zero.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int unsigned      CLK_DIV   = 500000,
  parameter int unsigned      LAP_DEPTH = 4,
  parameter logic [BCD_W-1:0] RESET_VAL = 24'h000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             lap_read,
  output logic [BCD_W-1:0] disp_bcd,
  output logic             running,
  output logic             frozen,
  output logic             overflow,
  output logic             lap_valid,
  output logic [BCD_W-1:0] lap_data,
  output logic             lap_overrun
);

  localparam int unsigned          PRESC_W   = $clog2(CLK_DIV);
  localparam logic [PRESC_W-1:0]   PRESC_MAX = PRESC_W'(CLK_DIV - 1);
  localparam logic [PRESC_W-1:0]   PRESC_ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0]   PRESC_ZERO = PRESC_W'(0);

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               frozen_q, frozen_d;
  logic               overflow_q, overflow_d;
  logic [BCD_W-1:0]   latch_q, latch_d;

  logic [BCD_W-1:0]   count_s;
  logic [6:0]         en_s;
  logic               tick_s, push_s, unfreeze_s, clear_s, wrap_s;

  // Events decoded from the state before this edge.
  assign tick_s     = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
  assign push_s     = lap && (state_q == ST_RUN);
  assign unfreeze_s = lap && (state_q == ST_PAUSE) && frozen_q;
  assign clear_s    = lap && (state_q == ST_PAUSE) && !frozen_q;

  // Six-digit ripple chain; a digit's carry enables the next in the same cycle.
  assign en_s[0] = tick_s;
  for (genvar k = 0; k < 6; k++) begin : g_digit
    bcd_digit #(
      .LIMIT  (digit_limit(k)),
      .RST_VAL(RESET_VAL[4*k +: 4])
    ) u_digit (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (clear_s),
      .en_i   (en_s[k]),
      .digit_o(count_s[4*k +: 4]),
      .carry_o(en_s[k+1])
    );
  end
  assign wrap_s = en_s[6];

  // Control next-state: prescaler, split latch, flags and run state.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    frozen_d   = frozen_q;
    overflow_d = overflow_q;
    latch_d    = latch_q;

    if (state_q == ST_RUN) begin
      presc_d = tick_s ? PRESC_ZERO : (presc_q + PRESC_ONE);
    end else begin
      presc_d = presc_q;
    end

    // Capture uses the pre-increment count even when a tick lands here.
    if (push_s) begin
      latch_d  = count_s;
      frozen_d = 1'b1;
    end else if (unfreeze_s) begin
      frozen_d = 1'b0;
    end else begin
      latch_d = latch_q;
    end

    if (wrap_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (clear_s) begin
      presc_d    = PRESC_ZERO;
      frozen_d   = 1'b0;
      overflow_d = 1'b0;
      state_d    = ST_IDLE;
    end else begin
      state_d = state_q;
    end

    // A simultaneous clear and start both land in RUN from a zero count.
    if (start_stop) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      state_d = state_d;
    end
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= PRESC_ZERO;
      frozen_q   <= 1'b0;
      overflow_q <= 1'b0;
      latch_q    <= 24'h000000;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      frozen_q   <= frozen_d;
      overflow_q <= overflow_d;
      latch_q    <= latch_d;
    end
  end

  assign disp_bcd = frozen_q ? latch_q : count_s;
  assign running  = (state_q == ST_RUN);
  assign frozen   = frozen_q;
  assign overflow = overflow_q;

`ifdef LAP_STOPWATCH_FIFO_EN
  localparam int unsigned        PTR_W   = $clog2(LAP_DEPTH);
  localparam int unsigned        CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(LAP_DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ZERO = PTR_W'(0);

  logic [BCD_W-1:0] fifo_mem_q [LAP_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lap_overrun_q, lap_overrun_d;
  logic             empty_s, full_s, pop_s, wr_en_s;

  assign empty_s = (cnt_q == CNT_ZERO);
  assign full_s  = (cnt_q == DEPTH_C);
  assign pop_s   = lap_read & ~empty_s;
  // A pop frees the slot this same push needs, so full+pop still accepts.
  assign wr_en_s = push_s & (~full_s | pop_s);

  // FIFO pointer, occupancy and overrun next-state.
  always_comb begin
    wr_ptr_d      = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d      = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    lap_overrun_d = lap_overrun_q | (push_s & full_s & ~pop_s);
    case ({wr_en_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q      <= PTR_ZERO;
      rd_ptr_q      <= PTR_ZERO;
      cnt_q         <= CNT_ZERO;
      lap_overrun_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      lap_overrun_q <= lap_overrun_d;
    end
  end

  // FIFO storage write; contents are only visible through the valid gate.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      fifo_mem_q[wr_ptr_q] <= count_s;
    end
  end

  assign lap_valid   = ~empty_s;
  assign lap_data    = empty_s ? 24'h000000 : fifo_mem_q[rd_ptr_q];
  assign lap_overrun = lap_overrun_q;
`else
  logic unused_fifo_s;
  assign unused_fifo_s = lap_read & (LAP_DEPTH != 32'd0);
  assign lap_valid     = 1'b0;
  assign lap_data      = 24'h000000;
  assign lap_overrun   = 1'b0;
`endif

endmodule
